multicycle_ctrl: RTL

//   Main control FSM of the multicycle 32-bit ARM-subset core. Steps every instruction

---
 rtl/multicycle_ctrl_if.sv | 35 +++
 rtl/multicycle_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the instruction register fields and the
// multicycle datapath: decoded inputs in, select/enable lines out.
interface multicycle_ctrl_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite;
    logic       NextPC;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ALUOp;
    logic [1:0] ResultSrc;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic       Done;
    logic       Undef;

    modport master (
        input  Op, Funct, MemReady,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB,
        output ALUOp, ResultSrc, RegW, MemW, Branch,
        output ImmSrc, RegSrc, Done, Undef
    );

    modport slave (
        output Op, Funct, MemReady,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB,
        input  ALUOp, ResultSrc, RegW, MemW, Branch,
        input  ImmSrc, RegSrc, Done, Undef
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle ARM-subset core: sequences
// fetch/decode/execute/writeback and drives datapath selects.
module multicycle_ctrl #(
    parameter bit TRAP_UNDEF = 1'b1
) (
    input logic clk,
    input logic reset,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXECR  = 4'd2,
        EXECI  = 4'd3,
        ALUWB  = 4'd4,
        MEMADR = 4'd5,
        MEMRD  = 4'd6,
        MEMWB  = 4'd7,
        MEMWR  = 4'd8,
        BRANCH = 4'd9,
        UNDEF  = 4'd10
    } state_t;

    state_t state;
    state_t state_n;

    logic       irwrite;
    logic       nextpc;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       aluop;
    logic [1:0] resultsrc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       done;
    logic       undef;

    logic op_dp;
    logic op_mem;
    logic op_br;
    logic op_undef;
    logic is_imm;
    logic is_load;
    logic unused_funct;

    assign op_dp        = (bus.Op == 2'b00);
    assign op_mem       = (bus.Op == 2'b01);
    assign op_br        = (bus.Op == 2'b10);
    assign op_undef     = (bus.Op == 2'b11);
    assign is_imm       = bus.Funct[5];
    assign is_load      = bus.Funct[0];
    assign unused_funct = ^bus.Funct[4:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = FETCH;
        irwrite   = 1'b0;
        nextpc    = 1'b0;
        adrsrc    = 1'b0;
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        aluop     = 1'b0;
        resultsrc = 2'b10;
        regw      = 1'b0;
        memw      = 1'b0;
        branch    = 1'b0;
        done      = 1'b0;
        undef     = 1'b0;

        unique case (state)
            FETCH: begin
                irwrite = bus.MemReady;
                nextpc  = bus.MemReady;
                state_n = bus.MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                unique case (1'b1)
                    op_dp & ~is_imm: state_n = EXECR;
                    op_dp &  is_imm: state_n = EXECI;
                    op_mem:          state_n = MEMADR;
                    op_br:           state_n = BRANCH;
                    op_undef: begin
                        state_n = TRAP_UNDEF ? UNDEF : FETCH;
                    end
                    default:         state_n = FETCH;
                endcase
            end
            EXECR: begin
                alusrca = 1'b0;
                alusrcb = 2'b00;
                aluop   = 1'b1;
                state_n = ALUWB;
            end
            EXECI: begin
                alusrca = 1'b0;
                alusrcb = 2'b01;
                aluop   = 1'b1;
                state_n = ALUWB;
            end
            ALUWB: begin
                resultsrc = 2'b00;
                regw      = 1'b1;
                done      = 1'b1;
                state_n   = FETCH;
            end
            MEMADR: begin
                alusrca = 1'b0;
                alusrcb = 2'b01;
                aluop   = 1'b0;
                state_n = is_load ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adrsrc  = 1'b1;
                state_n = bus.MemReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                resultsrc = 2'b01;
                regw      = 1'b1;
                done      = 1'b1;
                state_n   = FETCH;
            end
            MEMWR: begin
                // write strobe stays up for the whole wait
                adrsrc  = 1'b1;
                memw    = 1'b1;
                done    = bus.MemReady;
                state_n = bus.MemReady ? FETCH : MEMWR;
            end
            BRANCH: begin
                alusrca = 1'b0;
                alusrcb = 2'b01;
                aluop   = 1'b0;
                branch  = 1'b1;
                done    = 1'b1;
                state_n = FETCH;
            end
            UNDEF: begin
                undef   = 1'b1;
                state_n = UNDEF;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    // FETCH is also the reset state, so its MemReady gating is masked here
    assign bus.IRWrite   = irwrite & ~reset;
    assign bus.NextPC    = nextpc & ~reset;
    assign bus.AdrSrc    = adrsrc;
    assign bus.ALUSrcA   = alusrca;
    assign bus.ALUSrcB   = alusrcb;
    assign bus.ALUOp     = aluop;
    assign bus.ResultSrc = resultsrc;
    assign bus.RegW      = regw;
    assign bus.MemW      = memw;
    assign bus.Branch    = branch;
    assign bus.Done      = done;
    assign bus.Undef     = undef;

    assign bus.ImmSrc = op_undef ? 2'b00 : bus.Op;
    assign bus.RegSrc = {op_mem, op_br};

endmodule
